// File: rtl/alu_result_stage.sv
// alu_result_stage
// Registered result stage behind the 32-bit add/sub unit. It derives the
// Z/N/C/V flags from each incoming result and holds the results in a 2-entry
// skid buffer that drains in order toward writeback. It also keeps the
// architectural status flags and a saturating count of retired ops.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid / in_ready    upstream handshake (in_ready is a flop output)
//   in_result, in_cout     adder result and carry-out
//   in_funct               0 = add, 1 = sub
//   in_a_msb, in_b_msb     sign bits of the two operands
//   in_rd, in_wen          destination register and writeback enable
//   out_valid / out_ready  downstream handshake
//   out_result, out_rd,
//   out_wen, out_flags     head entry fields, flags packed as {Z,N,C,V}
//   stat_flags             flags of the most recently retired op
//   retired_cnt            saturating count of retired ops
module alu_result_stage #(
   parameter int WIDTH = 32,
   parameter int RD_W  = 5,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_result,
   input  logic             in_cout,
   input  logic             in_funct,
   input  logic             in_a_msb,
   input  logic             in_b_msb,
   input  logic [RD_W-1:0]  in_rd,
   input  logic             in_wen,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [RD_W-1:0]  out_rd,
   output logic             out_wen,
   output logic [3:0]       out_flags,
   output logic [3:0]       stat_flags,
   output logic [CNT_W-1:0] retired_cnt
);

   // Occupancy of the buffer: EMPTY, ONE (main register only), TWO (main + skid)
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             in_ready_q, in_ready_d;

   logic [WIDTH-1:0] main_result_q, main_result_d;
   logic [RD_W-1:0]  main_rd_q, main_rd_d;
   logic             main_wen_q, main_wen_d;
   logic [3:0]       main_flags_q, main_flags_d;

   logic [WIDTH-1:0] skid_result_q, skid_result_d;
   logic [RD_W-1:0]  skid_rd_q, skid_rd_d;
   logic             skid_wen_q, skid_wen_d;
   logic [3:0]       skid_flags_q, skid_flags_d;

   logic [3:0]       stat_flags_q, stat_flags_d;
   logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;

   logic             accept;
   logic             retire;
   logic [3:0]       in_flags;
   logic             flag_z, flag_n, flag_c, flag_v;

   // Condition flags of the incoming result. Carry is only meaningful for
   // add; overflow is a sign change that the operand signs cannot explain.
   always_comb begin
      flag_z = (in_result == '0);
      flag_n = in_result[WIDTH-1];
      flag_c = in_funct ? 1'b0 : in_cout;
      if (in_funct) begin
         flag_v = (in_a_msb != in_b_msb) & (in_result[WIDTH-1] != in_a_msb);
      end else begin
         flag_v = (in_a_msb == in_b_msb) & (in_result[WIDTH-1] != in_a_msb);
      end
      in_flags = {flag_z, flag_n, flag_c, flag_v};
   end

   // Next-state logic. The head is always the main register; a second entry
   // only lands in the skid register when the head cannot leave this cycle.
   // in_ready is computed from the next state so it is a plain flop output.
   always_comb begin
      accept        = in_valid & in_ready_q;
      retire        = (state_q != EMPTY) & out_ready;

      state_d       = state_q;
      main_result_d = main_result_q;
      main_rd_d     = main_rd_q;
      main_wen_d    = main_wen_q;
      main_flags_d  = main_flags_q;
      skid_result_d = skid_result_q;
      skid_rd_d     = skid_rd_q;
      skid_wen_d    = skid_wen_q;
      skid_flags_d  = skid_flags_q;
      stat_flags_d  = stat_flags_q;
      retired_cnt_d = retired_cnt_q;

      unique case (state_q)
         EMPTY: begin
            if (accept) begin
               main_result_d = in_result;
               main_rd_d     = in_rd;
               main_wen_d    = in_wen;
               main_flags_d  = in_flags;
               state_d       = ONE;
            end
         end
         ONE: begin
            if (accept && retire) begin
               main_result_d = in_result;
               main_rd_d     = in_rd;
               main_wen_d    = in_wen;
               main_flags_d  = in_flags;
            end else if (accept) begin
               skid_result_d = in_result;
               skid_rd_d     = in_rd;
               skid_wen_d    = in_wen;
               skid_flags_d  = in_flags;
               state_d       = TWO;
            end else if (retire) begin
               state_d       = EMPTY;
            end
         end
         TWO: begin
            if (retire) begin
               main_result_d = skid_result_q;
               main_rd_d     = skid_rd_q;
               main_wen_d    = skid_wen_q;
               main_flags_d  = skid_flags_q;
               state_d       = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase

      // Every retire updates the status flags, whether or not it writes back
      if (retire) begin
         stat_flags_d = main_flags_q;
         if (retired_cnt_q != '1) begin
            retired_cnt_d = retired_cnt_q + CNT_W'(1);
         end
      end

      in_ready_d = (state_d != TWO);
   end

   // State registers; reset discards buffered entries without retiring them
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= EMPTY;
         in_ready_q    <= 1'b1;
         main_result_q <= '0;
         main_rd_q     <= '0;
         main_wen_q    <= 1'b0;
         main_flags_q  <= 4'b0000;
         skid_result_q <= '0;
         skid_rd_q     <= '0;
         skid_wen_q    <= 1'b0;
         skid_flags_q  <= 4'b0000;
         stat_flags_q  <= 4'b0000;
         retired_cnt_q <= '0;
      end else begin
         state_q       <= state_d;
         in_ready_q    <= in_ready_d;
         main_result_q <= main_result_d;
         main_rd_q     <= main_rd_d;
         main_wen_q    <= main_wen_d;
         main_flags_q  <= main_flags_d;
         skid_result_q <= skid_result_d;
         skid_rd_q     <= skid_rd_d;
         skid_wen_q    <= skid_wen_d;
         skid_flags_q  <= skid_flags_d;
         stat_flags_q  <= stat_flags_d;
         retired_cnt_q <= retired_cnt_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = (state_q != EMPTY);
   assign out_result  = main_result_q;
   assign out_rd      = main_rd_q;
   assign out_wen     = main_wen_q;
   assign out_flags   = main_flags_q;
   assign stat_flags  = stat_flags_q;
   assign retired_cnt = retired_cnt_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage
// Directed bench for alu_result_stage. A second instance with a 4-bit
// retired-op counter shares all inputs so counter saturation can be observed
// alongside the full-width counter.
module tb_alu_result_stage;

   localparam int WIDTH = 32;
   localparam int RD_W  = 5;

   logic        clk = 1'b0;
   logic        rst;
   logic        inValid;
   logic        inReady;
   logic [31:0] inResult;
   logic        inCout;
   logic        inFunct;
   logic        inAMsb;
   logic        inBMsb;
   logic [4:0]  inRd;
   logic        inWen;
   logic        outValid;
   logic        outReady;
   logic [31:0] outResult;
   logic [4:0]  outRd;
   logic        outWen;
   logic [3:0]  outFlags;
   logic [3:0]  statFlags;
   logic [15:0] retiredCnt;

   logic        inReadyS;
   logic        outValidS;
   logic [31:0] outResultS;
   logic [4:0]  outRdS;
   logic        outWenS;
   logic [3:0]  outFlagsS;
   logic [3:0]  statFlagsS;
   logic [3:0]  retiredCntS;

   int testsRun    = 0;
   int testsFailed = 0;

   // 100 MHz clock
   always #5 clk = ~clk;

   alu_result_stage #(.WIDTH(WIDTH), .RD_W(RD_W), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .in_valid(inValid), .in_ready(inReady),
      .in_result(inResult), .in_cout(inCout), .in_funct(inFunct),
      .in_a_msb(inAMsb), .in_b_msb(inBMsb), .in_rd(inRd), .in_wen(inWen),
      .out_valid(outValid), .out_ready(outReady),
      .out_result(outResult), .out_rd(outRd), .out_wen(outWen),
      .out_flags(outFlags), .stat_flags(statFlags), .retired_cnt(retiredCnt)
   );

   alu_result_stage #(.WIDTH(WIDTH), .RD_W(RD_W), .CNT_W(4)) dutSmall (
      .clk(clk), .rst(rst),
      .in_valid(inValid), .in_ready(inReadyS),
      .in_result(inResult), .in_cout(inCout), .in_funct(inFunct),
      .in_a_msb(inAMsb), .in_b_msb(inBMsb), .in_rd(inRd), .in_wen(inWen),
      .out_valid(outValidS), .out_ready(outReady),
      .out_result(outResultS), .out_rd(outRdS), .out_wen(outWenS),
      .out_flags(outFlagsS), .stat_flags(statFlagsS), .retired_cnt(retiredCntS)
   );

   // Single comparison point: counts every check and reports any mismatch
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Advance one clock and land 1 ns past the edge, where outputs are settled
   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // Drive one upstream op onto the inputs
   task automatic applyStimulus(input logic valid, input logic [31:0] result,
                                input logic cout, input logic funct,
                                input logic aMsb, input logic bMsb,
                                input logic [4:0] rd, input logic wen);
      inValid  = valid;
      inResult = result;
      inCout   = cout;
      inFunct  = funct;
      inAMsb   = aMsb;
      inBMsb   = bMsb;
      inRd     = rd;
      inWen    = wen;
   endtask

   logic [31:0] streamVals [4];
   logic [31:0] gotVals [4];
   int          accepted;
   int          gotN;
   int          expIdx;
   int          orderErr;
   int          readyDrops;
   int          loopRetires;
   int          ghostValid;

   initial begin
      streamVals[0] = 32'h11;
      streamVals[1] = 32'h22;
      streamVals[2] = 32'h33;
      streamVals[3] = 32'h44;

      // Reset state
      rst      = 1'b1;
      outReady = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      stepCycle();
      stepCycle();
      checkOutput("reset out_valid", outValid, 0);
      checkOutput("reset in_ready", inReady, 1);
      checkOutput("reset out_result", outResult, 0);
      checkOutput("reset stat_flags", statFlags, 0);
      checkOutput("reset retired_cnt", retiredCnt, 0);
      rst = 1'b0;
      stepCycle();

      // Signed overflow on add: 0x7FFFFFFF + 1
      outReady = 1'b1;
      applyStimulus(1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1);
      stepCycle();
      inValid = 1'b0;
      checkOutput("add ovf out_valid", outValid, 1);
      checkOutput("add ovf out_result", outResult, 32'h8000_0000);
      checkOutput("add ovf out_rd", outRd, 3);
      checkOutput("add ovf out_flags", outFlags, 4'b0101);
      checkOutput("add ovf stat before retire", statFlags, 0);
      stepCycle();
      checkOutput("add ovf stat_flags", statFlags, 4'b0101);
      checkOutput("add ovf retired_cnt", retiredCnt, 1);
      checkOutput("add ovf drained", outValid, 0);

      // Zero result with carry: 0xFFFFFFFF + 1, no writeback
      applyStimulus(1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd5, 1'b0);
      stepCycle();
      inValid = 1'b0;
      checkOutput("add zero out_flags", outFlags, 4'b1010);
      checkOutput("add zero out_wen", outWen, 0);
      checkOutput("add zero out_rd", outRd, 5);
      stepCycle();
      checkOutput("add zero stat_flags", statFlags, 4'b1010);
      checkOutput("add zero retired_cnt", retiredCnt, 2);

      // Sub overflow: 0x80000000 - 1; carry-in from upstream must be masked
      applyStimulus(1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b0, 5'd9, 1'b1);
      stepCycle();
      inValid = 1'b0;
      checkOutput("sub ovf out_flags", outFlags, 4'b0001);
      stepCycle();
      checkOutput("sub ovf stat_flags", statFlags, 4'b0001);
      checkOutput("sub ovf retired_cnt", retiredCnt, 3);
      checkOutput("small cnt before sat", retiredCntS, 3);

      // Stall: four ops offered with out_ready low, only two fit
      outReady = 1'b0;
      accepted = 0;
      for (int c = 0; c < 4; c++) begin
         applyStimulus(1'b1, streamVals[accepted], 1'b0, 1'b0, 1'b0, 1'b0,
                       5'(accepted + 1), 1'b1);
         if (inReady) accepted++;
         stepCycle();
      end
      checkOutput("stall accepted", accepted, 2);
      checkOutput("stall in_ready", inReady, 0);
      checkOutput("stall head result", outResult, 32'h11);
      checkOutput("stall head rd", outRd, 1);

      // Release the stall and collect retirements in order
      outReady = 1'b1;
      gotN     = 0;
      for (int c = 0; c < 20 && gotN < 4; c++) begin
         if (accepted < 4) begin
            applyStimulus(1'b1, streamVals[accepted], 1'b0, 1'b0, 1'b0, 1'b0,
                          5'(accepted + 1), 1'b1);
         end else begin
            inValid = 1'b0;
         end
         if (outValid) begin
            gotVals[gotN] = outResult;
            gotN++;
         end
         if (inValid && inReady) accepted++;
         stepCycle();
      end
      inValid = 1'b0;
      checkOutput("stream retire count", gotN, 4);
      for (int k = 0; k < 4; k++) begin
         if (k < gotN) checkOutput($sformatf("stream order %0d", k), gotVals[k], streamVals[k]);
      end
      checkOutput("stream no extra", outValid, 0);
      checkOutput("stream retired_cnt", retiredCnt, 7);

      // 100 back-to-back ops with out_ready held high
      readyDrops  = 0;
      loopRetires = 0;
      expIdx      = 0;
      orderErr    = 0;
      for (int i = 0; i < 100; i++) begin
         applyStimulus(1'b1, 32'h100 + 32'(i), 1'b1, 1'b0, 1'b0, 1'b0, 5'd2, 1'b1);
         if (!inReady) readyDrops++;
         if (outValid) begin
            if (outResult !== 32'h100 + 32'(expIdx)) orderErr++;
            expIdx++;
            loopRetires++;
         end
         stepCycle();
      end
      inValid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         if (outValid) begin
            if (outResult !== 32'h100 + 32'(expIdx)) orderErr++;
            expIdx++;
         end
         stepCycle();
      end
      checkOutput("b2b in_ready drops", readyDrops, 0);
      checkOutput("b2b retires in loop", loopRetires, 99);
      checkOutput("b2b total retired", expIdx, 100);
      checkOutput("b2b order errors", orderErr, 0);
      checkOutput("b2b retired_cnt", retiredCnt, 107);
      checkOutput("b2b stat_flags", statFlags, 4'b0010);
      checkOutput("small cnt saturated", retiredCntS, 15);

      // Reset while two entries are held
      outReady = 1'b0;
      applyStimulus(1'b1, 32'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 1'b1);
      stepCycle();
      applyStimulus(1'b1, 32'hBB, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 1'b1);
      stepCycle();
      inValid = 1'b0;
      checkOutput("full in_ready", inReady, 0);
      rst = 1'b1;
      stepCycle();
      checkOutput("midreset out_valid", outValid, 0);
      checkOutput("midreset in_ready", inReady, 1);
      checkOutput("midreset stat_flags", statFlags, 0);
      checkOutput("midreset retired_cnt", retiredCnt, 0);
      checkOutput("midreset out_result", outResult, 0);
      checkOutput("midreset out_flags", outFlags, 0);

      // An op presented during reset must be dropped
      applyStimulus(1'b1, 32'hCC, 1'b0, 1'b0, 1'b0, 1'b0, 5'd4, 1'b1);
      stepCycle();
      rst      = 1'b0;
      inValid  = 1'b0;
      outReady = 1'b1;
      ghostValid = 0;
      for (int c = 0; c < 4; c++) begin
         if (outValid) ghostValid++;
         stepCycle();
      end
      checkOutput("post reset no ghosts", ghostValid, 0);
      checkOutput("post reset retired_cnt", retiredCnt, 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
